// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: reset address,
// FSM state encoding and the sequential word increment.
package instr_fetch_pkg;

   // First fetch address after reset (word aligned).
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Byte distance between consecutive instruction words.
   localparam logic [31:0] WORD_INC = 32'd4;

   // FETCH drives the memory request, HOLD presents the instruction.
   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetchState_t;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for the fetch stage.
// Jump wins over a taken branch; otherwise fall through to pc+4.
// All arithmetic is 32-bit with wrap-around.
module next_pc_logic
   import instr_fetch_pkg::*;
(
   input  logic [31:0] instr_pc,
   input  logic        br_taken,
   input  logic [31:0] br_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   output logic [31:0] next_pc
);

   logic [31:0] seqPc;
   logic [31:0] branchPc;
   logic [31:0] jumpPc;

   // Candidate targets, all relative to the address after the consumed word.
   always_comb begin
      seqPc    = instr_pc + WORD_INC;
      branchPc = seqPc + (br_offset << 2);
      jumpPc   = {seqPc[31:28], jump_index, 2'b00};
   end

   // Priority select: jump, then taken branch, then sequential.
   always_comb begin
      next_pc = seqPc;
      if (jump) begin
         next_pc = jumpPc;
      end else if (br_taken) begin
         next_pc = branchPc;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word over a req/ack
// handshake, then holds it for the decoder until consumed. The redirect
// decided by the decoder is applied on the consuming edge, so the target
// address is on imem_addr the very next cycle.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        br_taken,
   input  logic [31:0] br_offset,
   input  logic        jump,
   input  logic [25:0] jump_index
);

   fetchState_t stateReg;
   fetchState_t stateNext;
   logic [31:0] pcReg;
   logic [31:0] pcNext;
   logic [31:0] instrReg;
   logic [31:0] instrPcReg;
   logic [31:0] targetPc;
   logic        captureInstr;

   // Redirect target computed from the held instruction's address.
   next_pc_logic uNextPc (
      .instr_pc   (instrPcReg),
      .br_taken   (br_taken),
      .br_offset  (br_offset),
      .jump       (jump),
      .jump_index (jump_index),
      .next_pc    (targetPc)
   );

   // Next-state logic: capture on ack in FETCH, advance PC on consume in HOLD.
   always_comb begin
      stateNext    = stateReg;
      pcNext       = pcReg;
      captureInstr = 1'b0;
      case (stateReg)
         FETCH: begin
            if (imem_ack) begin
               captureInstr = 1'b1;
               stateNext    = HOLD;
            end
         end
         HOLD: begin
            if (instr_ready) begin
               pcNext    = targetPc;
               stateNext = FETCH;
            end
         end
         default: begin
            stateNext = FETCH;
         end
      endcase
   end

   // State and PC registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateReg <= FETCH;
         pcReg    <= RESET_PC;
      end else begin
         stateReg <= stateNext;
         pcReg    <= pcNext;
      end
   end

   // Instruction register and its address, frozen outside the capture edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instrReg   <= '0;
         instrPcReg <= '0;
      end else if (captureInstr) begin
         instrReg   <= imem_rdata;
         instrPcReg <= pcReg;
      end
   end

   // Outputs decoded straight from registered state.
   always_comb begin
      imem_req    = (stateReg == FETCH);
      instr_valid = (stateReg == HOLD);
      imem_addr   = pcReg;
      instr       = instrReg;
      instr_pc    = instrPcReg;
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by a
// randomized run, with a queue-based scoreboard checked by a monitor.
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        br_taken;
   logic [31:0] br_offset;
   logic        jump;
   logic [25:0] jump_index;

   int errors = 0;
   int checks = 0;

   // Scoreboard entry: expected instruction word and its address.
   typedef struct {
      logic [31:0] word;
      logic [31:0] pc;
   } expEntry_t;

   expEntry_t expQ[$];

   // Reference model state.
   logic [31:0] refPc;
   logic [31:0] refInstrPc;
   bit          refInHold;
   bit          prevValid;

   instr_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .br_taken    (br_taken),
      .br_offset   (br_offset),
      .jump        (jump),
      .jump_index  (jump_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Next PC straight from the architectural rules.
   function automatic logic [31:0] refNext(input logic [31:0] p, input bit br,
                                           input logic [31:0] off, input bit jmp,
                                           input logic [25:0] idx);
      logic [31:0] s;
      s = p + 32'd4;
      if (jmp) return (s & 32'hF000_0000) | ({6'b0, idx} << 2);
      if (br) return s + off * 32'd4;
      return s;
   endfunction

   // One clock cycle, called at a falling edge: check the visible state,
   // drive inputs for the next rising edge, advance the model.
   task automatic cycle(input bit ackIn, input logic [31:0] dataIn, input bit readyIn,
                        input bit brIn, input logic [31:0] offIn, input bit jmpIn,
                        input logic [25:0] idxIn);
      check("imem_req", {31'b0, imem_req}, {31'b0, !refInHold});
      check("instr_valid", {31'b0, instr_valid}, {31'b0, refInHold});
      if (!refInHold) check("imem_addr", imem_addr, refPc);
      imem_ack    = ackIn;
      imem_rdata  = dataIn;
      instr_ready = readyIn;
      br_taken    = brIn;
      br_offset   = offIn;
      jump        = jmpIn;
      jump_index  = idxIn;
      if (!refInHold) begin
         if (ackIn) begin
            expQ.push_back('{word: dataIn, pc: refPc});
            refInstrPc = refPc;
            refInHold  = 1'b1;
         end
      end else if (readyIn) begin
         refPc     = refNext(refInstrPc, brIn, offIn, jmpIn, idxIn);
         refInHold = 1'b0;
      end
      @(negedge clk);
   endtask

   // Convenience: complete a zero-wait fetch.
   task automatic fetchNow(input logic [31:0] data);
      cycle(1'b1, data, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
   endtask

   // Convenience: consume the held instruction with a given redirect.
   task automatic consume(input bit brIn, input logic [31:0] offIn, input bit jmpIn,
                          input logic [25:0] idxIn);
      cycle(1'b0, $urandom, 1'b1, brIn, offIn, jmpIn, idxIn);
   endtask

   // Monitor: each new instruction presented is checked against the queue.
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         prevValid = 1'b0;
      end else begin
         if (instr_valid && !prevValid) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_instr: got pc 0x%08h with empty scoreboard", instr_pc);
            end else begin
               expEntry_t e;
               e = expQ.pop_front();
               check("instr", instr, e.word);
               check("instr_pc", instr_pc, e.pc);
               $display("txn pc=0x%08h instr=0x%08h", instr_pc, instr);
            end
         end
         prevValid = instr_valid;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst         = 1'b1;
      imem_ack    = 1'b0;
      imem_rdata  = '0;
      instr_ready = 1'b0;
      br_taken    = 1'b0;
      br_offset   = '0;
      jump        = 1'b0;
      jump_index  = '0;
      refPc       = RESET_PC;
      refInstrPc  = '0;
      refInHold   = 1'b0;

      // Reset state, observed while reset is held.
      #3;
      check("rst_req", {31'b0, imem_req}, 32'd1);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("first_addr", imem_addr, RESET_PC);

      // Zero-wait sequential run: 0, 4, then a 3-cycle wait at 8, then 12.
      fetchNow($urandom); consume(1'b0, 32'h0, 1'b0, 26'h0);
      check("seq_addr4", imem_addr, 32'h4);
      fetchNow($urandom); consume(1'b0, 32'h0, 1'b0, 26'h0);
      check("seq_addr8", imem_addr, 32'h8);
      for (int w = 0; w < 3; w++) begin
         cycle(1'b0, $urandom, 1'b1, 1'b1, $urandom, 1'b1, 26'h3FFFFFF);
         check("wait_addr8", imem_addr, 32'h8);
      end
      fetchNow(32'hDEAD_BEEF);
      check("wait_instr", instr, 32'hDEAD_BEEF);
      consume(1'b0, 32'h0, 1'b0, 26'h0);
      check("seq_addr12", imem_addr, 32'hC);

      // Jump to 0x100, then a backward branch to 0xFC.
      fetchNow($urandom); consume(1'b0, 32'h0, 1'b1, 26'h40);
      check("jump_0x100", imem_addr, 32'h100);
      fetchNow($urandom); consume(1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0);
      check("branch_back", imem_addr, 32'hFC);
      fetchNow($urandom); consume(1'b0, 32'h0, 1'b0, 26'h0);
      check("seq_0x100", imem_addr, 32'h100);
      // Jump and branch together at 0x100: jump wins.
      fetchNow($urandom); consume(1'b1, 32'hFFFF_FFFE, 1'b1, 26'h40);
      check("jump_priority", imem_addr, 32'h100);
      // Branch pulsed while not consumed is ignored.
      fetchNow($urandom);
      cycle(1'b0, $urandom, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 26'h0);
      consume(1'b0, 32'h0000_0100, 1'b0, 26'h0);
      check("ignored_branch", imem_addr, 32'h104);
      // Branch to the last word, then wrap to 0.
      fetchNow($urandom); consume(1'b1, 32'hFFFF_FFBD, 1'b0, 26'h0);
      check("branch_top", imem_addr, 32'hFFFF_FFFC);
      fetchNow($urandom); consume(1'b0, 32'h0, 1'b0, 26'h0);
      check("wrap_zero", imem_addr, 32'h0);

      // Randomized traffic.
      for (int t = 0; t < 150; t++) begin
         int waits;
         int holds;
         waits = $urandom_range(0, 3);
         holds = $urandom_range(0, 2);
         for (int w = 0; w < waits; w++)
            cycle(1'b0, $urandom, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 26'($urandom));
         cycle(1'b1, $urandom, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 26'($urandom));
         for (int h = 0; h < holds; h++)
            cycle(1'b0, $urandom, 1'b0, 1'($urandom), $urandom, 1'($urandom), 26'($urandom));
         consume(($urandom_range(0, 3) == 0), {{16{1'($urandom)}}, 16'($urandom)},
                 ($urandom_range(0, 4) == 0), 26'($urandom));
      end

      // Reset pulse in the middle of HOLD.
      fetchNow(32'h1234_5678);
      imem_ack = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst_valid", {31'b0, instr_valid}, 32'd0);
      check("midrst_req", {31'b0, imem_req}, 32'd1);
      check("midrst_instr", instr, 32'h0);
      check("midrst_instr_pc", instr_pc, 32'h0);
      #1 rst = 1'b0;
      expQ.delete();
      refPc     = RESET_PC;
      refInHold = 1'b0;
      @(negedge clk);
      check("post_rst_addr", imem_addr, RESET_PC);
      fetchNow($urandom); consume(1'b0, 32'h0, 1'b0, 26'h0);
      check("post_rst_seq", imem_addr, 32'h4);
      @(negedge clk);

      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
